// File: rtl/start_resp_monitor_pkg.sv
// start_resp_mon_pkg
//   Shared types and helpers for the start/response protocol monitor.
//   - ch_state_t : per-channel FSM state (IDLE, WAIT)
//   - dly_width  : width of the delay counter for a given MAX_DLY
//   - popcount   : number of set bits in an event vector (up to POP_MAX)
package start_resp_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_t;

    // Widest event vector popcount accepts; the top refuses larger NUM_CH.
    localparam int POP_MAX = 64;

    // Counter must hold offsets 0..MAX_DLY, so size it for MAX_DLY+1 values.
    // Each instance derives its own DLY_W from its MAX_DLY via this function.
    function automatic int dly_width(input int max_dly);
        return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/start_resp_monitor_ch.sv
// start_resp_ch
//   One monitored channel: start edge detector, IDLE/WAIT FSM and delay
//   counter. Produces single-cycle, combinational event strobes for the
//   edge that is about to be taken; the top registers them.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   en           : accept new start rises
//   start        : start level for this channel
//   resp         : response vector for this channel
//   resp_mask    : bits of resp that must be 1
//   pass_evt     : this edge closes the window with a pass
//   fail_evt     : this edge closes the window with a fail (window expired)
//   overlap_evt  : a rise arrived while the window stays open
module start_resp_ch
    import start_resp_mon_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] resp,
    input  logic [WIDTH-1:0] resp_mask,
    output logic             pass_evt,
    output logic             fail_evt,
    output logic             overlap_evt
);

    localparam int DLY_W = dly_width(MAX_DLY);

    ch_state_t        state;
    logic             start_q;
    logic [DLY_W-1:0] cnt;

    logic             rise;
    logic             ok;
    logic [DLY_W-1:0] k;
    logic             in_window;
    logic             done;

    assign rise = start & ~start_q;

    // Masked-off bits are forced to 1, so an all-zero mask always passes.
    assign ok = &(resp | ~resp_mask);

    // cnt holds (edges already spent in WAIT); the edge being evaluated is
    // offset k = cnt+1 from the rise. cnt never exceeds MAX_DLY-1, so k fits.
    assign k         = cnt + DLY_W'(1);
    assign in_window = (state == WAIT) && (k >= DLY_W'(MIN_DLY));

    assign pass_evt    = in_window & ok;
    assign fail_evt    = (state == WAIT) && !pass_evt && (k == DLY_W'(MAX_DLY));
    assign done        = pass_evt | fail_evt;
    // A rise on the completing edge starts a fresh window instead.
    assign overlap_evt = (state == WAIT) && rise && !done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (rise && en) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (done) begin
                        if (rise && en) begin
                            state <= WAIT;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        // Overlapping rises are dropped; the window keeps going.
                        cnt <= k;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/start_resp_monitor.sv
// start_resp_monitor
//   Start/response protocol monitor for NUM_CH independent channels. A rising
//   start opens a window of MIN_DLY..MAX_DLY edges in which the masked
//   response must be all-ones on at least one edge.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   en           : accept new start rises
//   clr          : clear counters and sticky flags (wins over same-cycle events)
//   start        : per-channel start level
//   resp         : channel c at [c*WIDTH +: WIDTH]
//   resp_mask    : required-one bits, shared by all channels
//   pass_pulse   : one-cycle pass per channel, after the deciding edge
//   fail_pulse   : one-cycle fail per channel, after the deciding edge
//   overlap_err  : sticky, rise seen while the channel window was open
//   any_fail     : sticky, any fail event on any channel
//   pass_cnt     : saturating pass count
//   fail_cnt     : saturating fail count
module start_resp_monitor
    import start_resp_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 8,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH*WIDTH-1:0] resp,
    input  logic [WIDTH-1:0]        resp_mask,
    output logic [NUM_CH-1:0]       pass_pulse,
    output logic [NUM_CH-1:0]       fail_pulse,
    output logic [NUM_CH-1:0]       overlap_err,
    output logic                    any_fail,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt
);

    if (MIN_DLY < 1) begin : g_bad_min
        $error("start_resp_monitor: MIN_DLY must be >= 1");
    end
    if (MAX_DLY < MIN_DLY) begin : g_bad_max
        $error("start_resp_monitor: MAX_DLY must be >= MIN_DLY");
    end
    if (NUM_CH < 1 || NUM_CH > POP_MAX) begin : g_bad_ch
        $error("start_resp_monitor: NUM_CH out of range");
    end

    localparam int INC_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = CNT_W + INC_W;

    logic [NUM_CH-1:0] pass_evt;
    logic [NUM_CH-1:0] fail_evt;
    logic [NUM_CH-1:0] ovl_evt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        start_resp_ch #(
            .WIDTH   (WIDTH),
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .start       (start[c]),
            .resp        (resp[c*WIDTH +: WIDTH]),
            .resp_mask   (resp_mask),
            .pass_evt    (pass_evt[c]),
            .fail_evt    (fail_evt[c]),
            .overlap_evt (ovl_evt[c])
        );
    end

    logic [INC_W-1:0] pass_inc;
    logic [INC_W-1:0] fail_inc;
    logic [SUM_W-1:0] pass_sum;
    logic [SUM_W-1:0] fail_sum;
    logic [CNT_W-1:0] pass_next;
    logic [CNT_W-1:0] fail_next;

    assign pass_inc = INC_W'(popcount(POP_MAX'(pass_evt)));
    assign fail_inc = INC_W'(popcount(POP_MAX'(fail_evt)));

    // Add in a widened adder so overflow is visible in the top bits, then
    // clamp to all-ones instead of wrapping.
    assign pass_sum = SUM_W'(pass_cnt) + SUM_W'(pass_inc);
    assign fail_sum = SUM_W'(fail_cnt) + SUM_W'(fail_inc);

    assign pass_next = (|pass_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
    assign fail_next = (|fail_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pass_pulse  <= '0;
            fail_pulse  <= '0;
            overlap_err <= '0;
            any_fail    <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            // Pulses always reflect the edge's events, even under clr.
            pass_pulse <= pass_evt;
            fail_pulse <= fail_evt;
            if (clr) begin
                overlap_err <= '0;
                any_fail    <= 1'b0;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
            end else begin
                overlap_err <= overlap_err | ovl_evt;
                any_fail    <= any_fail | (|fail_evt);
                pass_cnt    <= pass_next;
                fail_cnt    <= fail_next;
            end
        end
    end

endmodule

// File: tb/tb_start_resp_monitor.sv
// Bench for start_resp_monitor. Two instances share all inputs:
//   dut0: defaults (MIN_DLY=1, MAX_DLY=4, CNT_W=16)
//   dut1: MIN_DLY=2, MAX_DLY=3, CNT_W=2
// A timestamp-based reference model tracks both; directed tasks check
// hand-derived values, the random task checks every cycle against the model.
module tb_start_resp_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [3:0]  start;
    logic [31:0] resp;
    logic [7:0]  resp_mask;

    logic [3:0]  d0_pass, d0_fail, d0_ovl;
    logic        d0_any;
    logic [15:0] d0_pcnt, d0_fcnt;
    logic [3:0]  d1_pass, d1_fail, d1_ovl;
    logic        d1_any;
    logic [1:0]  d1_pcnt, d1_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    start_resp_monitor u_d0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .start(start), .resp(resp),
        .resp_mask(resp_mask), .pass_pulse(d0_pass), .fail_pulse(d0_fail),
        .overlap_err(d0_ovl), .any_fail(d0_any), .pass_cnt(d0_pcnt), .fail_cnt(d0_fcnt)
    );

    start_resp_monitor #(.NUM_CH(4), .WIDTH(8), .MIN_DLY(2), .MAX_DLY(3), .CNT_W(2)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .start(start), .resp(resp),
        .resp_mask(resp_mask), .pass_pulse(d1_pass), .fail_pulse(d1_fail),
        .overlap_err(d1_ovl), .any_fail(d1_any), .pass_cnt(d1_pcnt), .fail_cnt(d1_fcnt)
    );

    // ---------------- reference model ----------------
    // Each open window remembers the edge number at which it opened; an
    // edge n is inside the window when min <= n - t0 <= max.
    int          mn [2] = '{1, 2};
    int          mx [2] = '{4, 3};
    int          cmax [2] = '{65535, 3};
    int          cyc_n = 0;
    bit          busy [2][4];
    int          t0 [2][4];
    logic [3:0]  sprev;
    logic [3:0]  m_pass [2];
    logic [3:0]  m_fail [2];
    logic [3:0]  m_ovl [2];
    logic        m_any [2];
    int          m_pcnt [2];
    int          m_fcnt [2];

    always @(posedge clk) begin : model
        logic [3:0] pv, fv, ov;
        bit rise, ok, done;
        int k;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) busy[d][c] = 1'b0;
                m_pass[d] = '0; m_fail[d] = '0; m_ovl[d] = '0; m_any[d] = 1'b0;
                m_pcnt[d] = 0; m_fcnt[d] = 0;
            end
            sprev = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                pv = '0; fv = '0; ov = '0;
                for (int c = 0; c < 4; c++) begin
                    rise = start[c] && !sprev[c];
                    ok   = ((resp[c*8 +: 8] | ~resp_mask) == 8'hFF);
                    done = 1'b0;
                    if (busy[d][c]) begin
                        k = cyc_n - t0[d][c];
                        if (k >= mn[d] && ok) pv[c] = 1'b1;
                        else if (k == mx[d]) fv[c] = 1'b1;
                        done = pv[c] | fv[c];
                        if (done) busy[d][c] = 1'b0;
                        if (rise && !done) ov[c] = 1'b1;
                    end
                    if (rise && en && !busy[d][c] && (done || !ov[c])) begin
                        busy[d][c] = 1'b1;
                        t0[d][c]   = cyc_n;
                    end
                end
                m_pass[d] = pv;
                m_fail[d] = fv;
                if (clr) begin
                    m_pcnt[d] = 0; m_fcnt[d] = 0; m_ovl[d] = '0; m_any[d] = 1'b0;
                end else begin
                    m_pcnt[d] = (m_pcnt[d] + $countones(pv) > cmax[d]) ? cmax[d] : m_pcnt[d] + $countones(pv);
                    m_fcnt[d] = (m_fcnt[d] + $countones(fv) > cmax[d]) ? cmax[d] : m_fcnt[d] + $countones(fv);
                    m_ovl[d]  = m_ovl[d] | ov;
                    m_any[d]  = m_any[d] | (|fv);
                end
            end
            sprev = start;
        end
        cyc_n++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_all();
        start = '0; resp = '0; resp_mask = 8'hFF; en = 1'b1; clr = 1'b0;
        cyc(6);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; en = 1'b1; clr = 1'b0; start = '0; resp = '0; resp_mask = 8'hFF;
        cyc(3);
        checks++;
        if ({d0_pass, d0_fail, d0_ovl, d0_any, d0_pcnt, d0_fcnt} !== '0) begin
            errors++; $display("FAIL reset_d0 got %h expected 0", {d0_pass, d0_fail, d0_ovl, d0_any, d0_pcnt, d0_fcnt});
        end
        checks++;
        if ({d1_pass, d1_fail, d1_ovl, d1_any, d1_pcnt, d1_fcnt} !== '0) begin
            errors++; $display("FAIL reset_d1 got %h expected 0", {d1_pass, d1_fail, d1_ovl, d1_any, d1_pcnt, d1_fcnt});
        end
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_pass_basic();
        idle_all();
        start = 4'b0001;
        cyc(1);                       // T
        cyc(1);                       // T+1, resp not ok
        checks++;
        if (d0_pass !== 4'b0000) begin errors++; $display("FAIL pass_early got %b expected 0000", d0_pass); end
        resp[7:0] = 8'hFF;
        cyc(1);                       // T+2
        checks++;
        if (d0_pass !== 4'b0001) begin errors++; $display("FAIL pass_basic got %b expected 0001", d0_pass); end
        checks++;
        if (d0_pcnt !== 16'd1 || d0_fcnt !== 16'd0) begin
            errors++; $display("FAIL pass_cnt got %0d/%0d expected 1/0", d0_pcnt, d0_fcnt);
        end
        checks++;
        if (d1_pass !== 4'b0001) begin errors++; $display("FAIL pass_d1 got %b expected 0001", d1_pass); end
        resp = '0; start = '0;
        cyc(1);
        checks++;
        if (d0_pass !== 4'b0000) begin errors++; $display("FAIL pass_one_cycle got %b expected 0000", d0_pass); end
    endtask

    task automatic test_fail_timeout();
        idle_all();
        start = 4'b0010;
        cyc(1);                       // T
        cyc(3);                       // T+3
        checks++;
        if (d0_fail !== 4'b0000 || d1_fail !== 4'b0010) begin
            errors++; $display("FAIL fail_t3 got %b/%b expected 0000/0010", d0_fail, d1_fail);
        end
        cyc(1);                       // T+4
        checks++;
        if (d0_fail !== 4'b0010 || d0_fcnt !== 16'd1 || d0_any !== 1'b1) begin
            errors++; $display("FAIL fail_t4 got %b cnt %0d any %b expected 0010 1 1", d0_fail, d0_fcnt, d0_any);
        end
        start = '0; resp_mask = 8'h00;
        cyc(2);
        start = 4'b0010;
        cyc(1);                       // T
        cyc(1);                       // T+1
        checks++;
        if (d0_pass !== 4'b0010 || d1_pass !== 4'b0000) begin
            errors++; $display("FAIL zero_mask got %b/%b expected 0010/0000", d0_pass, d1_pass);
        end
        cyc(1);                       // T+2
        checks++;
        if (d1_pass !== 4'b0010) begin errors++; $display("FAIL zero_mask_d1 got %b expected 0010", d1_pass); end
        resp_mask = 8'hFF; start = '0;
    endtask

    task automatic test_window_cfg();
        idle_all();
        start = 4'b0001;
        cyc(1);                       // T
        resp[7:0] = 8'hFF;
        cyc(1);                       // T+1: before dut1 window
        checks++;
        if (d1_pass !== 4'b0000 || d0_pass !== 4'b0001) begin
            errors++; $display("FAIL win_early got %b/%b expected 0001/0000", d0_pass, d1_pass);
        end
        resp = '0;
        cyc(2);                       // T+3
        checks++;
        if (d1_fail !== 4'b0001) begin errors++; $display("FAIL win_fail got %b expected 0001", d1_fail); end
        start = '0;
        cyc(2);
        start = 4'b0001;
        cyc(1);                       // T
        cyc(2);                       // T+2
        checks++;
        if (d1_fail !== 4'b0000 || d1_pass !== 4'b0000) begin
            errors++; $display("FAIL win_mid got %b/%b expected 0000/0000", d1_pass, d1_fail);
        end
        resp[7:0] = 8'hFF;
        cyc(1);                       // T+3: last edge of dut1 window
        checks++;
        if (d1_pass !== 4'b0001 || d1_fail !== 4'b0000) begin
            errors++; $display("FAIL win_last got %b/%b expected 0001/0000", d1_pass, d1_fail);
        end
        resp = '0; start = '0;
    endtask

    task automatic test_overlap();
        idle_all();
        start = 4'b0100;
        cyc(1);                       // T
        start = '0;
        cyc(1);                       // T+1
        start = 4'b0100;
        cyc(1);                       // T+2
        checks++;
        if (d0_ovl !== 4'b0100 || d1_ovl !== 4'b0100) begin
            errors++; $display("FAIL overlap got %b/%b expected 0100/0100", d0_ovl, d1_ovl);
        end
        start = '0;
        cyc(1);                       // T+3
        checks++;
        if (d0_fail !== 4'b0000) begin errors++; $display("FAIL ovl_t3 got %b expected 0000", d0_fail); end
        cyc(1);                       // T+4
        checks++;
        if (d0_fail !== 4'b0100) begin errors++; $display("FAIL ovl_t4 got %b expected 0100", d0_fail); end
        cyc(4);
        checks++;
        if (d0_fcnt !== 16'd1 || d1_fcnt !== 2'd1 || d0_ovl !== 4'b0100) begin
            errors++; $display("FAIL ovl_single got %0d/%0d ovl %b expected 1/1 0100", d0_fcnt, d1_fcnt, d0_ovl);
        end
    endtask

    task automatic test_back_to_back();
        idle_all();
        start = 4'b0100;
        cyc(1);                       // T
        start = '0;
        cyc(3);                       // T+3
        start = 4'b0100;
        cyc(1);                       // T+4: completion edge and new rise
        checks++;
        if (d0_fail !== 4'b0100 || d0_ovl !== 4'b0000) begin
            errors++; $display("FAIL b2b_t4 got %b ovl %b expected 0100 0000", d0_fail, d0_ovl);
        end
        cyc(4);                       // T+8
        checks++;
        if (d0_fail !== 4'b0100 || d0_fcnt !== 16'd2 || d0_ovl !== 4'b0000) begin
            errors++; $display("FAIL b2b_t8 got %b cnt %0d ovl %b expected 0100 2 0000", d0_fail, d0_fcnt, d0_ovl);
        end
        checks++;
        if (d1_fcnt !== 2'd2 || d1_ovl !== 4'b0000) begin
            errors++; $display("FAIL b2b_d1 got %0d ovl %b expected 2 0000", d1_fcnt, d1_ovl);
        end
        start = '0;
    endtask

    task automatic test_saturate();
        idle_all();
        resp = '1;
        for (int r = 1; r <= 2; r++) begin
            start = 4'hF;
            cyc(1);                   // T
            cyc(1);                   // T+1
            checks++;
            if (d0_pass !== 4'hF || d0_pcnt !== 16'(4 * r)) begin
                errors++; $display("FAIL all_pass r%0d got %b cnt %0d expected 1111 %0d", r, d0_pass, d0_pcnt, 4 * r);
            end
            cyc(1);                   // T+2
            checks++;
            if (d1_pass !== 4'hF || d1_pcnt !== 2'd3) begin
                errors++; $display("FAIL sat r%0d got %b cnt %0d expected 1111 3", r, d1_pass, d1_pcnt);
            end
            start = '0;
            cyc(2);
        end
        resp = '0;
    endtask

    task automatic test_reset_mid_wait();
        idle_all();
        start = 4'b1000;
        cyc(2);                       // T, T+1
        rst = 1'b0;
        cyc(1);
        checks++;
        if ({d0_pass, d0_fail, d0_pcnt, d0_fcnt, d1_pass, d1_fail, d1_pcnt, d1_fcnt} !== '0) begin
            errors++; $display("FAIL rst_mid got %h expected 0", {d0_pass, d0_fail, d0_pcnt, d0_fcnt, d1_pass, d1_fail});
        end
        rst = 1'b1;
        cyc(1);                       // R: held start counts as a rise
        for (int i = 1; i <= 2; i++) begin
            cyc(1);                   // R+1, R+2
            checks++;
            if (d0_fail !== 4'b0000 || d1_fail !== 4'b0000) begin
                errors++; $display("FAIL rst_abandon R+%0d got %b/%b expected 0000/0000", i, d0_fail, d1_fail);
            end
        end
        cyc(1);                       // R+3
        checks++;
        if (d1_fail !== 4'b1000 || d0_fail !== 4'b0000) begin
            errors++; $display("FAIL rst_rise_d1 got %b/%b expected 0000/1000", d0_fail, d1_fail);
        end
        cyc(1);                       // R+4
        checks++;
        if (d0_fail !== 4'b1000) begin errors++; $display("FAIL rst_rise_d0 got %b expected 1000", d0_fail); end
        start = '0;
    endtask

    task automatic test_clr();
        idle_all();
        resp = '1;
        start = 4'b0001;
        cyc(1);                       // T
        clr = 1'b1;
        cyc(1);                       // T+1
        checks++;
        if (d0_pass !== 4'b0001 || d0_pcnt !== 16'd0) begin
            errors++; $display("FAIL clr_pass got %b cnt %0d expected 0001 0", d0_pass, d0_pcnt);
        end
        clr = 1'b0;
        cyc(1);                       // T+2
        checks++;
        if (d1_pass !== 4'b0001 || d1_pcnt !== 2'd1) begin
            errors++; $display("FAIL clr_after got %b cnt %0d expected 0001 1", d1_pass, d1_pcnt);
        end
        resp = '0; start = '0;
    endtask

    task automatic test_en_low();
        idle_all();
        en = 1'b0;
        start = 4'hF;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            checks++;
            if ({d0_pass, d0_fail, d0_ovl, d1_pass, d1_fail, d1_ovl} !== '0 || d0_fcnt !== 16'd0) begin
                errors++; $display("FAIL en_low cyc %0d got %h expected 0", i, {d0_pass, d0_fail, d0_ovl, d1_pass, d1_fail, d1_ovl});
            end
        end
        en = 1'b1; start = '0;
        cyc(1);
    endtask

    task automatic test_random();
        logic [3:0] ap, af, ao;
        logic       aa;
        int         apc, afc;
        idle_all();
        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin ap = d0_pass; af = d0_fail; ao = d0_ovl; aa = d0_any; apc = int'(d0_pcnt); afc = int'(d0_fcnt); end
                else        begin ap = d1_pass; af = d1_fail; ao = d1_ovl; aa = d1_any; apc = int'(d1_pcnt); afc = int'(d1_fcnt); end
                checks++;
                if ({ap, af, ao, aa} !== {m_pass[d], m_fail[d], m_ovl[d], m_any[d]}) begin
                    errors++;
                    $display("FAIL rand_flags dut%0d n %0d got p%b f%b o%b a%b expected p%b f%b o%b a%b",
                             d, n, ap, af, ao, aa, m_pass[d], m_fail[d], m_ovl[d], m_any[d]);
                end
                checks++;
                if (apc !== m_pcnt[d] || afc !== m_fcnt[d]) begin
                    errors++;
                    $display("FAIL rand_cnt dut%0d n %0d got %0d/%0d expected %0d/%0d", d, n, apc, afc, m_pcnt[d], m_fcnt[d]);
                end
            end
            rst = ($urandom_range(0, 199) != 0);
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 9) < 3) start[c] = ~start[c];
            end
            case ($urandom_range(0, 3))
                0:       resp_mask = 8'h00;
                1:       resp_mask = 8'hFF;
                default: resp_mask = 8'($urandom);
            endcase
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 9) < 3) resp[c*8 +: 8] = resp_mask | 8'($urandom);
                else                          resp[c*8 +: 8] = 8'($urandom) & 8'($urandom);
            end
            cyc(1);
        end
        rst = 1'b1; en = 1'b1; clr = 1'b0; start = '0; resp = '0;
    endtask

    initial begin
        test_reset();
        test_pass_basic();
        test_fail_timeout();
        test_window_cfg();
        test_overlap();
        test_back_to_back();
        test_saturate();
        test_reset_mid_wait();
        test_clr();
        test_en_low();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/start_resp_monitor.md
Name: start_resp_monitor

Overview:
- Synthesizable, parametrised start/response protocol monitor for NUM_CH independent channels.
- Per channel: a rising edge on start opens a response window of MIN_DLY..MAX_DLY cycles. The masked response vector must be all-ones at some edge inside that window.
- Reports per-channel pass/fail pulses, sticky overlap errors and saturating aggregate counters. Instantiated beside DUT interfaces in simulation and emulation.

Parameters:
NUM_CH, 4, number of monitored channels
WIDTH, 8, response vector width per channel
MIN_DLY, 1, first check edge after the rise (>=1)
MAX_DLY, 4, last check edge after the rise (>=MIN_DLY)
CNT_W, 16, pass/fail counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
en  input  1  accept new start rises when 1
clr  input  1  synchronous clear of counters and sticky flags
start  input  NUM_CH  per-channel start level
resp  input  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
resp_mask  input  WIDTH  bits that must be 1; masked-off bits are don't-care
pass_pulse  output  NUM_CH  one-cycle pass indication
fail_pulse  output  NUM_CH  one-cycle fail indication
overlap_err  output  NUM_CH  sticky: rise seen while channel busy
any_fail  output  1  sticky OR of all fail events
pass_cnt  output  CNT_W  saturating count of passes
fail_cnt  output  CNT_W  saturating count of fails

Behaviour:
- Reset (rst==0 at a posedge):
  - all outputs 0, every channel in IDLE, start history register 0.
  - A start held high across reset release therefore counts as a rise on the first active edge.
  - Reset mid-WAIT abandons the transaction with no pulse.
- Rise detection: rise[c] = start[c] & ~start_q[c]; start_q is registered every cycle.
- Condition: ok[c] = &(resp_c | ~resp_mask). An all-zero mask always passes.
- Per-channel FSM states: IDLE, WAIT. Rise sampled at edge T.
  - IDLE: rise & en -> WAIT, delay counter=0. Rise with en=0 is ignored; no error is raised.
  - WAIT: the counter increments each edge; edge T+k is a check edge when MIN_DLY<=k<=MAX_DLY.
    - ok at a check edge -> pass, return to IDLE.
    - ok before T+MIN_DLY -> ignored.
    - no ok by T+MAX_DLY -> fail at edge T+MAX_DLY, return to IDLE.
  - en deasserted during WAIT does not affect the in-flight transaction.
- Outputs are registered: pass_pulse/fail_pulse go high for exactly one cycle, after the deciding edge.
- Overlap:
  - A rise while in WAIT that does not complete at that edge sets overlap_err[c]; the new rise is dropped and the original window continues.
  - A rise on the same edge where WAIT completes (pass or fail) is accepted as a new transaction (if en=1); no overlap_err.
- Counters:
  - pass_cnt += popcount(pass events that edge); fail_cnt likewise.
  - Adder width is CNT_W+$clog2(NUM_CH+1); the result saturates at 2^CNT_W-1 and never wraps.
  - any_fail is set on any fail event.
- clr: clears pass_cnt, fail_cnt, overlap_err, any_fail. It does not affect FSMs or pulses.
  - clr wins over same-cycle increments/sets; those events are lost from counters but pulses still fire.
- MIN_DLY=MAX_DLY=1, NUM_CH=1 reproduces the single-cycle "rise implies next-cycle condition" check.
- Elaboration-time error if MIN_DLY<1 or MAX_DLY<MIN_DLY.

Decomposition:
- Package start_resp_mon_pkg:
  - ch_state_t enum {IDLE, WAIT}.
  - Localparam DLY_W = $clog2(MAX_DLY+1) computed per instance.
  - popcount function.
- Sub-module start_resp_ch: per-channel edge detect, FSM and delay counter, producing pass/fail/overlap events. Generated NUM_CH times.
- Top level holds the output registers, counters, saturation and clr logic.

Test Plan:
1. Defaults; rst=0 for 3 cycles; ch0 start rises at T; resp ch0=8'hFF, mask=8'hFF at T+2 -> pass_pulse[0]=1 for one cycle after T+2, pass_cnt=1, fail_cnt=0.
2. Rise ch1 at T; resp held 0 -> fail_pulse[1] after edge T+4, fail_cnt=1, any_fail=1. mask=8'h00 repeated -> pass at T+1.
3. MIN_DLY=2, MAX_DLY=3; resp ok only at T+1 -> fail after T+3. Resp ok at T+3 -> pass.
4. Overlap:
   - ch2 rises at T and again at T+2 (resp 0) -> overlap_err[2]=1, exactly one fail_pulse at T+4.
   - Re-rise exactly at the completion edge -> second window runs, no overlap_err.
5. All 4 channels pass on the same edge -> pass_cnt +4. With CNT_W=2, repeat -> pass_cnt holds at 3.
6. Reset and clear:
   - rst=0 mid-WAIT -> no pulses, counters 0, start held high causes a new rise after release.
   - clr coincident with a pass -> pass_pulse fires, pass_cnt=0.
   - en=0 with a rise -> no activity.
